// File: rtl/ulbf_data_axis2ram_64b_pkg.sv
// Shared types and constants for the ULBF data-path capture engine.
package ulbf_data_pkg;

  localparam int ULBF_ADDR_W = 16;
  localparam int ULBF_CNT_W  = 12;
  localparam logic [ULBF_ADDR_W-1:0] ULBF_ERR_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } ulbf_state_e;

  // Increment that sticks at the saturation value instead of wrapping.
  function automatic logic [ULBF_ADDR_W-1:0] ulbf_sat_inc(input logic [ULBF_ADDR_W-1:0] val);
    return (val == ULBF_ERR_SAT) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/ulbf_data_axis2ram_64b_if.sv
// AXI4-Stream bundle carrying the AI Engine return stream into the capture engine.
interface ulbf_data_axis2ram_64b_if #(
  parameter int TDATA_WIDTH = 64
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   s00_axis_tvalid;
  logic                   s00_axis_tready;
  logic [TDATA_WIDTH-1:0] s00_axis_tdata;
  logic [TKEEP_WIDTH-1:0] s00_axis_tkeep;
  logic                   s00_axis_tlast;

  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tkeep, s00_axis_tlast,
    input  s00_axis_tready
  );

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tkeep, s00_axis_tlast,
    output s00_axis_tready
  );

endinterface

// File: rtl/ulbf_data_axis2ram_64b_sdp_ram.sv
// Simple dual-port RAM: byte-masked write port, read-first registered read port.
module ulbf_data_sdp_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int BW    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [BW-1:0]    wbe,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Byte-lane writes; contents survive reset so a capture can be read after an abort.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BW; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read data holds when no read is requested; the array read sees pre-write contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Registered read output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ulbf_data_axis2ram_64b.sv
// Capture engine: writes a run of AXI4-Stream blocks into local RAM with TLAST framing checks.
module ulbf_data_axis2ram_64b
  import ulbf_data_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int RAM_DEPTH   = 2048,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   s_axis_clk,
  input  logic                   s_axis_rst_n,
  input  logic                   go,
  input  logic [ULBF_CNT_W-1:0]  niter,
  input  logic [ULBF_CNT_W-1:0]  block_size,
  input  logic [ADDR_WIDTH-1:0]  rollover_addr,
  ulbf_data_axis2ram_64b_if.slave s00_axis,
  output logic                   done,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  addrb_wire,
  output logic [ULBF_ADDR_W-1:0] tlast_err_cnt,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [TDATA_WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  ulbf_state_e state_q, state_d;
  logic go_q, go_d;
  logic start_q, start_d;
  logic tready_q, tready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  roll_q, roll_d;
  logic [ULBF_CNT_W-1:0]  beat_q, beat_d;
  logic [ULBF_CNT_W-1:0]  iter_q, iter_d;
  logic [ULBF_CNT_W-1:0]  niter_q, niter_d;
  logic [ULBF_CNT_W-1:0]  bsize_q, bsize_d;
  logic [ULBF_ADDR_W-1:0] err_q, err_d;

  logic                   hs;
  logic                   block_end;
  logic                   last_block;
  logic                   rd_ok;
  logic [TKEEP_WIDTH-1:0] wr_be;

  assign wr_be = s00_axis.s00_axis_tkeep;

  // Next-state, counters, framing check and registered-output decode.
  always_comb begin
    hs         = s00_axis.s00_axis_tvalid & tready_q;
    block_end  = (beat_q == bsize_q - 1'b1);
    last_block = (iter_q == niter_q - 1'b1);
    go_d       = go;
    start_d    = go & ~go_q;
    state_d    = state_q;
    addr_d     = addr_q;
    roll_d     = roll_q;
    beat_d     = beat_q;
    iter_d     = iter_q;
    niter_d    = niter_q;
    bsize_d    = bsize_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start_q && (niter != '0) && (block_size != '0)) begin
          state_d = CAPTURE;
          addr_d  = '0;
          beat_d  = '0;
          iter_d  = '0;
          err_d   = '0;
          niter_d = niter;
          bsize_d = block_size;
          roll_d  = (rollover_addr >= ADDR_WIDTH'(RAM_DEPTH)) ? LAST_ADDR : rollover_addr;
        end
      end
      CAPTURE: begin
        if (hs) begin
          addr_d = (addr_q == roll_q) ? '0 : addr_q + 1'b1;
          if (block_end) begin
            beat_d = '0;
            iter_d = iter_q + 1'b1;
            if (!s00_axis.s00_axis_tlast) err_d = ulbf_sat_inc(err_q);
            if (last_block) state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            if (s00_axis.s00_axis_tlast) err_d = ulbf_sat_inc(err_q);
          end
        end
      end
      DONE: begin
        if (!go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d == CAPTURE);
    busy_d   = (state_d == CAPTURE);
    done_d   = (state_d == DONE);
  end

  // State, configuration latch and counters; reset aborts any run in progress.
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      state_q  <= IDLE;
      go_q     <= 1'b0;
      start_q  <= 1'b0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      roll_q   <= '0;
      beat_q   <= '0;
      iter_q   <= '0;
      niter_q  <= '0;
      bsize_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      start_q  <= start_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      roll_q   <= roll_d;
      beat_q   <= beat_d;
      iter_q   <= iter_d;
      niter_q  <= niter_d;
      bsize_q  <= bsize_d;
      err_q    <= err_d;
    end
  end

  assign s00_axis.s00_axis_tready = tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign addrb_wire    = addr_q;
  assign tlast_err_cnt = err_q;

  // Reads beyond the RAM leave the previous readback value in place.
  assign rd_ok = rd_en && (rd_addr < ADDR_WIDTH'(RAM_DEPTH));

  ulbf_data_sdp_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (TDATA_WIDTH)
  ) u_ram (
    .clk   (s_axis_clk),
    .rst_n (s_axis_rst_n),
    .we    (hs),
    .wbe   (wr_be),
    .waddr (addr_q[AW-1:0]),
    .wdata (s00_axis.s00_axis_tdata),
    .re    (rd_ok),
    .raddr (rd_addr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_ulbf_data_axis2ram_64b.sv
// Directed bench for the capture engine with a beat-level reference model.
module tb_ulbf_data_axis2ram_64b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [11:0] niter = '0;
  logic [11:0] block_size = '0;
  logic [15:0] rollover_addr = '0;
  logic        done;
  logic        busy;
  logic [15:0] addrb_wire;
  logic [15:0] tlast_err_cnt;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [63:0] rd_data;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  ulbf_data_axis2ram_64b_if bus ();

  ulbf_data_axis2ram_64b dut (
    .s_axis_clk    (clk),
    .s_axis_rst_n  (rst_n),
    .go            (go),
    .niter         (niter),
    .block_size    (block_size),
    .rollover_addr (rollover_addr),
    .s00_axis      (bus.slave),
    .done          (done),
    .busy          (busy),
    .addrb_wire    (addrb_wire),
    .tlast_err_cnt (tlast_err_cnt),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 capturing, 2 done.
  logic [63:0] mem_m [2048];
  int m_phase = 0;
  int m_cnt = 0;
  int m_err = 0;
  int m_addr = 0;
  int m_niter = 0;
  int m_bs = 1;
  int m_roll = 0;
  bit m_go_q = 1'b0;
  bit m_start = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances one clock: a start edge is acted on one cycle after it is sampled.
  always @(posedge clk or negedge rst_n) begin
    bit start_now;
    int pos;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_err = 0; m_addr = 0; m_go_q = 1'b0; m_start = 1'b0;
    end else begin
      start_now = m_start && (m_phase == 0) && (niter != 0) && (block_size != 0);
      m_start = go && !m_go_q;
      m_go_q = go;
      if (start_now) begin
        m_phase = 1; m_cnt = 0; m_err = 0; m_addr = 0;
        m_niter = niter; m_bs = block_size;
        m_roll = (rollover_addr >= 2048) ? 2047 : rollover_addr;
      end else if (m_phase == 1) begin
        if (bus.s00_axis_tvalid) begin
          for (int b = 0; b < 8; b++)
            if (bus.s00_axis_tkeep[b]) mem_m[m_addr][b*8 +: 8] = bus.s00_axis_tdata[b*8 +: 8];
          pos = m_cnt % m_bs;
          if ((pos == m_bs - 1) != bus.s00_axis_tlast) m_err = (m_err < 65535) ? m_err + 1 : 65535;
          m_cnt++;
          m_addr = m_cnt % (m_roll + 1);
          if (m_cnt == m_niter * m_bs) m_phase = 2;
        end
      end else if (m_phase == 2 && !go) begin
        m_phase = 0;
      end
    end
  end

  // Every cycle the status outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("tready", bus.s00_axis_tready, m_phase == 1);
      checkOutput("busy", busy, m_phase == 1);
      checkOutput("done", done, m_phase == 2);
      checkOutput("addrb_wire", addrb_wire, m_addr);
      checkOutput("tlast_err_cnt", tlast_err_cnt, m_err);
    end
  end

  // Presents one beat after gap idle cycles and holds it until accepted (bounded).
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input bit l, input int gap);
    bit acc = 1'b0;
    bus.s00_axis_tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s00_axis_tvalid = 1'b1;
    bus.s00_axis_tdata = d;
    bus.s00_axis_tkeep = k;
    bus.s00_axis_tlast = l;
    for (int n = 0; n < 64; n++) begin
      acc = bus.s00_axis_tready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) checkOutput("handshake_timeout", acc, 1'b1);
    bus.s00_axis_tvalid = 1'b0;
  endtask

  task automatic startRun(input int n, input int bs, input int roll);
    niter = 12'(n);
    block_size = 12'(bs);
    rollover_addr = 16'(roll);
    go = 1'b1;
  endtask

  task automatic finishRun();
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checkOutput("done_seen", seen, 1'b1);
  endtask

  task automatic endRun();
    go = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic readCheck(input string name, input int a, input logic [63:0] exp);
    rd_en = 1'b1;
    rd_addr = 16'(a);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    checkOutput(name, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tdata = '0;
    bus.s00_axis_tkeep = '0;
    bus.s00_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tready", bus.s00_axis_tready, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_addr", addrb_wire, 16'd0);
    checkOutput("rst_err", tlast_err_cnt, 16'd0);
    checkOutput("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic run");
    startRun(2, 4, 15);
    for (int i = 0; i < 8; i++) applyStimulus(64'(i), 8'hFF, (i % 4) == 3, 0);
    checkOutput("basic_done_next", done, 1'b1);
    finishRun();
    checkOutput("basic_addr", addrb_wire, 16'd8);
    checkOutput("basic_err", tlast_err_cnt, 16'd0);
    endRun();
    for (int i = 0; i < 8; i++) readCheck("basic_ram", i, 64'(i));

    $display("[TB] wrap run");
    startRun(1, 5, 2);
    for (int i = 0; i < 5; i++) applyStimulus(64'(10 + i), 8'hFF, i == 4, 0);
    finishRun();
    checkOutput("wrap_addr", addrb_wire, 16'd2);
    endRun();
    readCheck("wrap_ram0", 0, 64'hD);
    readCheck("wrap_ram1", 1, 64'hE);
    readCheck("wrap_ram2", 2, 64'hC);

    $display("[TB] framing run");
    startRun(1, 4, 15);
    applyStimulus(64'h10, 8'hFF, 1'b0, 0);
    applyStimulus(64'h11, 8'hFF, 1'b1, 0);
    applyStimulus(64'h12, 8'hFF, 1'b0, 0);
    applyStimulus(64'h13, 8'hFF, 1'b0, 0);
    finishRun();
    checkOutput("frame_err", tlast_err_cnt, 16'd2);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("frame_done_held", done, 1'b1);
    endRun();

    $display("[TB] backpressure and byte enables");
    startRun(1, 1, 15);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 0);
    finishRun();
    endRun();
    startRun(2, 4, 15);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        go = 1'b0; @(posedge clk); #1; go = 1'b1;
      end
      applyStimulus((i == 0) ? 64'h1122_3344_5566_7788 : 64'(32'hA000 + i),
                    (i == 0) ? 8'h0F : 8'hFF, (i % 4) == 3, int'($urandom_range(0, 3)));
    end
    finishRun();
    endRun();
    readCheck("bytes_ram0", 0, 64'hFFFF_FFFF_5566_7788);
    for (int i = 1; i < 8; i++) readCheck("bytes_ram_model", i, mem_m[i]);

    $display("[TB] reset mid-run");
    startRun(1, 8, 15);
    for (int i = 0; i < 3; i++) applyStimulus(64'(32'h100 + i), 8'hFF, 1'b0, 0);
    rst_n = 1'b0;
    go = 1'b0;
    #1;
    checkOutput("abort_tready", bus.s00_axis_tready, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) readCheck("abort_ram", i, 64'(32'h100 + i));
    startRun(0, 4, 15);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("zero_niter_busy", busy, 1'b0);
    checkOutput("zero_niter_tready", bus.s00_axis_tready, 1'b0);
    go = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ulbf_data_axis2ram_64b.md
# ulbf_data_axis2ram_64b

AXI4-Stream slave capture engine for the ULBF beamforming PL data path: accepts the 64-bit stream returned by the AI Engine over PLIO and writes it into a local RAM. Capture is run-controlled by a `go` pulse, block size, iteration count and rollover address. It checks TLAST framing per block and exposes a registered readback port for the control-plane BRAM bridge. It is the receive-side counterpart of the `ulbf_data_ram2axis_64b` stream source.

## Interface
- `TDATA_WIDTH`, 64, stream data width (fixed 64 in this revision)
- `TKEEP_WIDTH`, TDATA_WIDTH/8, byte-enable width
- `RAM_DEPTH`, 2048, capture RAM depth in 64-bit words
- `ADDR_WIDTH`, 16, width of address/rollover ports
- `s_axis_clk` in 1: single clock for stream, control and readback
- `s_axis_rst_n` in 1: asynchronous, active-low reset
- `go` in 1: run request; rising edge starts a capture
- `niter` in 12: blocks to capture per run
- `block_size` in 12: beats per block
- `rollover_addr` in 16: last RAM address before wrapping to 0
- `s00_axis_tvalid` in 1, `s00_axis_tready` out 1: stream handshake
- `s00_axis_tdata` in 64, `s00_axis_tkeep` in 8, `s00_axis_tlast` in 1: stream payload
- `done` out 1: run complete
- `busy` out 1: capture in progress
- `addrb_wire` out 16: current RAM write address
- `tlast_err_cnt` out 16: saturating count of TLAST framing errors this run
- `rd_en` in 1, `rd_addr` in 16, `rd_data` out 64: readback port

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE: a rising edge of `go` (registered edge detect) moves to CAPTURE, provided `niter` and `block_size` are both nonzero.
  - On that transition, clear write address, beat counter, iteration counter and `tlast_err_cnt`.
  - If either field is zero, ignore the edge and stay in IDLE.
- Latch `niter`, `block_size` and `rollover_addr` on the start edge. Later changes have no effect until the next run.
- Clamp a latched `rollover_addr` ≥ RAM_DEPTH to RAM_DEPTH-1.
- CAPTURE: `s00_axis_tready`=1 and `busy`=1.
  - Each handshake (tvalid&tready) writes tdata to RAM[addr], byte-masked by tkeep.
  - addr then increments, or wraps to 0 when addr == rollover_addr.
- Framing is counted strictly by `block_size`. TLAST never resynchronises the beat counter.
  - Last beat of a block without TLAST: +1 error.
  - TLAST on any other beat: +1 error.
  - `tlast_err_cnt` saturates at 0xFFFF.
- At the block-end beat, the beat counter returns to 0 and the iteration counter increments.
  - At the block-end beat of iteration niter-1, move to DONE.
- DONE: `done`=1, `tready`=0, `busy`=0.
  - When `go` is low, return to IDLE and clear `done`.
  - `go` held high keeps DONE; a new run needs a fresh rising edge.
- A `go` edge during CAPTURE is ignored.
- Readback: read-first synchronous RAM port, independent of FSM state. A readback during a same-address write returns the old data.
- Reset mid-run: immediate return to IDLE. All outputs go to reset values. RAM contents are not cleared.

## Timing
- Reset values: `s00_axis_tready`=0, `done`=0, `busy`=0, `addrb_wire`=0, `tlast_err_cnt`=0, `rd_data`=0.
- `go` rises before edge N (sampled at edge N): state is CAPTURE after edge N+1, so `tready` is high in cycle N+1.
- Final handshake at edge K: `tready`=0 and `done`=1 from cycle K+1. No beat is accepted after the final one.
- `tready` is driven from the state register only. It never depends on `tvalid` combinationally.
- Write latency: a handshake at edge K is visible to readback issued at edge ≥ K+1.
- Readback: `rd_en` at edge R gives `rd_data` valid after edge R+1. `rd_data` holds its value when `rd_en`=0.
- Throughput: one beat per cycle with no bubbles, including across block and wrap boundaries.

## Structure
- Shared package `ulbf_data_pkg` holds:
  - the state enum (IDLE/CAPTURE/DONE);
  - the `ULBF_ADDR_W`=16 and `ULBF_CNT_W`=12 constants;
  - the `ULBF_ERR_SAT`=16'hFFFF constant.
- One sub-module, `ulbf_data_sdp_ram`: simple dual-port RAM with byte write enables, read-first behaviour and 1-cycle registered read, parameterised by depth and width.
- FSM, counters and framing check live in the top level.

## Test plan
- **Basic run:** `block_size`=4, `niter`=2, `rollover_addr`=15, 8 beats with data 0..7 and TLAST on beats 3 and 7 → `done` after beat 7, RAM[0..7]=0..7, `tlast_err_cnt`=0, `addrb_wire`=8.
- **Wrap:** `rollover_addr`=2, `block_size`=5, `niter`=1, data A..E → RAM[0]=D, RAM[1]=E, RAM[2]=C, `addrb_wire`=2.
- **Framing errors:** `block_size`=4, `niter`=1, TLAST on beat 1 and missing on beat 3 → `tlast_err_cnt`=2. `done` still asserts after beat 3.
- **Backpressure and byte enables:** random `tvalid` gaps with tkeep=0x0F on beat 0 over pre-written 0xFFFF…FF → RAM[0] upper 4 bytes stay 0xFF. `tready` stays 1 throughout CAPTURE.
- **Reset and control:** assert `s_axis_rst_n`=0 after 3 of 8 beats → `tready`=0, `busy`=0 immediately; RAM[0..2] retained. A subsequent `go` with `niter`=0 is ignored and the block stays in IDLE.
